fetch_unit: RTL and testbench

//   Instruction-fetch reader that consumes the PC from the program-counter stage and returns one decoded
//   Y86-64 instruction. Reads the byte-wide instruction memory serially from PC, sizes the instruction from

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: serial Y86-64 instruction fetch. Reads one byte per accepted memory beat
// starting at the captured PC, sizes the instruction from icode and assembles the fields.
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   pc_valid/pc_ready   PC handshake (ready only in IDLE), PC = fetch address
//   mem_rd/mem_addr     byte read request at pc_q + cnt
//   mem_rdata/mem_valid/mem_err  returned byte, beat strobe, fault flag
//   out_valid/out_ready decoded-instruction handshake
//   icode/ifun/rA/rB/valC/instr_len/imem_error/instr_invalid  decoded result
module fetch_unit #(
    parameter int DATA_WID = 64
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                pc_valid,
    output logic                pc_ready,
    input  logic [DATA_WID-1:0] PC,
    output logic                mem_rd,
    output logic [DATA_WID-1:0] mem_addr,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_valid,
    input  logic                mem_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          icode,
    output logic [3:0]          ifun,
    output logic [3:0]          rA,
    output logic [3:0]          rB,
    output logic [DATA_WID-1:0] valC,
    output logic [3:0]          instr_len,
    output logic                imem_error,
    output logic                instr_invalid
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t              r_state, w_next;
    logic [DATA_WID-1:0] r_pc;
    logic [3:0]          r_cnt;
    logic [3:0]          w_icode, w_len, w_cidx;
    logic                w_take, w_last, w_invalid, w_regs, w_const;
    // On byte 0 the icode is still on the bus, afterwards it comes from the register.
    assign w_icode   = (r_cnt == 4'd0) ? mem_rdata[7:4] : icode;
    assign w_len     = (w_icode == 4'h2 || w_icode == 4'h6 || w_icode == 4'hA || w_icode == 4'hB) ? 4'd2 :
                       (w_icode == 4'h7 || w_icode == 4'h8) ? 4'd9 :
                       (w_icode == 4'h3 || w_icode == 4'h4 || w_icode == 4'h5) ? 4'd10 : 4'd1;
    assign w_take    = (r_state == FETCH) && mem_valid;
    assign w_last    = (r_cnt + 4'd1) == w_len;
    assign w_invalid = (r_cnt == 4'd0) && (mem_rdata[7:4] > 4'hB);
    assign w_regs    = (r_cnt == 4'd1) && (w_len == 4'd2 || w_len == 4'd10);
    assign w_const   = (w_len == 4'd9 && r_cnt >= 4'd1) || (w_len == 4'd10 && r_cnt >= 4'd2);
    // Constant byte index: the constant follows the regs byte when one is present.
    assign w_cidx    = (w_len == 4'd10) ? r_cnt - 4'd2 : r_cnt - 4'd1;
    assign pc_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign mem_rd    = r_state == FETCH;
    assign mem_addr  = mem_rd ? r_pc + DATA_WID'(r_cnt) : '0;
    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = pc_valid ? FETCH : IDLE;
            FETCH:   w_next = (w_take && (mem_err || w_invalid || w_last)) ? DONE : FETCH;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pc          <= '0;
            r_cnt         <= '0;
            icode         <= '0;
            ifun          <= '0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= '0;
            instr_len     <= '0;
            imem_error    <= 1'b0;
            instr_invalid <= 1'b0;
        end else if (r_state == IDLE && pc_valid) begin
            r_pc          <= PC;
            r_cnt         <= '0;
            icode         <= '0;
            ifun          <= '0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= '0;
            instr_len     <= '0;
            imem_error    <= 1'b0;
            instr_invalid <= 1'b0;
        end else if (w_take) begin
            r_cnt <= r_cnt + 4'd1;
            // A faulted beat carries no usable data; report how many good bytes arrived.
            if (mem_err) begin
                imem_error <= 1'b1;
                instr_len  <= r_cnt;
            end else begin
                if (r_cnt == 4'd0) {icode, ifun} <= mem_rdata;
                if (w_regs) {rA, rB} <= mem_rdata;
                if (w_const) valC[{w_cidx[2:0], 3'b000} +: 8] <= mem_rdata;
                if (w_invalid) begin
                    instr_invalid <= 1'b1;
                    instr_len     <= 4'd1;
                end else if (w_last) begin
                    instr_len <= w_len;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a byte memory responder
module tb_fetch_unit;
    logic        CLK = 0, RST_N = 0, pc_valid = 0, out_ready = 0;
    logic [63:0] PC = '0;
    logic        pc_ready, mem_rd, mem_valid, mem_err, out_valid, imem_error, instr_invalid;
    logic [63:0] mem_addr, valC;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB, instr_len;
    logic [7:0]  mem [0:1023];
    logic        mv = 1, me = 0;
    int          n_cmp = 0, n_bad = 0;
    typedef struct packed {
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc;
        logic [3:0]  len;
        logic        err, inv;
    } exp_t;
    exp_t sb[$];
    fetch_unit #(.DATA_WID(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .pc_valid(pc_valid), .pc_ready(pc_ready), .PC(PC),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_err(mem_err), .out_valid(out_valid), .out_ready(out_ready), .icode(icode),
        .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .instr_len(instr_len),
        .imem_error(imem_error), .instr_invalid(instr_invalid)
    );
    assign mem_rdata = mem[mem_addr[9:0]];
    assign mem_valid = mem_rd & mv;
    assign mem_err   = me;
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t mk(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                                input logic [3:0] len, input logic err, inv);
        return '{ic: ic, fn: fn, ra: ra, rb: rb, vc: vc, len: len, err: err, inv: inv};
    endfunction
    task automatic load(input logic [63:0] pc, input logic [79:0] bytes, input int n);
        for (int i = 0; i < n; i++) mem[10'(pc + 64'(i))] = bytes[79 - 8*i -: 8];
    endtask
    task automatic fetch(input logic [63:0] pc, input exp_t e, input int lat, input int nrd,
                         input int stall_k, input int stall_n, input int err_k,
                         input int hold, input int rst_k);
        int   n = 1, k = 0, left = stall_n;
        exp_t g;
        chk("pc_ready", pc_ready, 1);
        PC = pc;
        pc_valid = 1;
        if (rst_k < 0) sb.push_back(e);
        @(posedge CLK); #1;
        pc_valid = 0;
        while (!out_valid && n < 100) begin
            mv = !(k == stall_k && left > 0);
            if (!mv) left--;
            me = (k == err_k);
            #1;
            if (k == rst_k) begin
                RST_N = 0;
                @(posedge CLK); #1;
                RST_N = 1;
                mv = 1;
                me = 0;
                chk("rst_mem_rd", mem_rd, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_pc_ready", pc_ready, 1);
                return;
            end
            if (mem_valid) begin
                chk("addr", mem_addr, pc + 64'(k));
                k++;
            end
            @(posedge CLK); #1;
            n++;
        end
        mv = 1;
        me = 0;
        chk("latency", n, lat);
        chk("reads", k, nrd);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_icode", icode, e.ic);
            chk("hold_inv", instr_invalid, e.inv);
            @(posedge CLK); #1;
        end
        if (sb.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
            g = sb.pop_front();
            chk("out_valid", out_valid, 1);
            chk("icode", icode, g.ic);
            chk("ifun", ifun, g.fn);
            chk("rA", rA, g.ra);
            chk("rB", rB, g.rb);
            chk("valC", valC, g.vc);
            chk("instr_len", instr_len, g.len);
            chk("imem_error", imem_error, g.err);
            chk("instr_invalid", instr_invalid, g.inv);
        end
        out_ready = 1;
        @(posedge CLK); #1;
        out_ready = 0;
        chk("released", out_valid, 0);
        chk("ready_again", pc_ready, 1);
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc_ready", pc_ready, 1);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_icode", icode, 0);
        chk("rst_ifun", ifun, 0);
        chk("rst_rA", rA, 4'hF);
        chk("rst_rB", rB, 4'hF);
        chk("rst_valC", valC, 0);
        chk("rst_len", instr_len, 0);
        chk("rst_err", imem_error, 0);
        chk("rst_inv", instr_invalid, 0);
        RST_N = 1;
        @(posedge CLK); #1;
        load(64'h100, {8'h00, 72'h0}, 1);
        fetch(64'h100, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 4'd1, 0, 0), 2, 1, -1, 0, -1, 0, -1);
        load(64'h200, 80'h30F30807060504030201, 10);
        fetch(64'h200, mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 4'd10, 0, 0), 11, 10, -1, 0, -1, 0, -1);
        load(64'h300, 80'h73112233445566778800, 9);
        fetch(64'h300, mk(4'h7, 4'h3, 4'hF, 4'hF, 64'h8877665544332211, 4'd9, 0, 0), 12, 9, 4, 2, -1, 0, -1);
        load(64'h040, {8'hC0, 72'h0}, 1);
        fetch(64'h040, mk(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 4'd1, 0, 1), 2, 1, -1, 0, -1, 3, -1);
        load(64'h080, 80'h4012A1A2A3A4A5A6A7A8, 10);
        fetch(64'h080, mk(4'h4, 4'h0, 4'h1, 4'h2, 64'hA3A2A1, 4'd5, 1, 0), 7, 6, -1, 0, 5, 0, -1);
        load(64'h0C0, 80'h30F41122334455667788, 10);
        fetch(64'h0C0, mk(4'h3, 4'h0, 4'hF, 4'h4, 64'h0, 4'd10, 0, 0), 0, 0, -1, 0, -1, 0, 3);
        load(64'hFFFF_FFFF_FFFF_FFFF, {16'h2012, 64'h0}, 2);
        fetch(64'hFFFF_FFFF_FFFF_FFFF, mk(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 4'd2, 0, 0), 3, 2, -1, 0, -1, 0, -1);
        load(64'h180, {16'h6123, 64'h0}, 2);
        fetch(64'h180, mk(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 4'd2, 0, 0), 3, 2, -1, 0, -1, 0, -1);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
